td4_run_ctrl: RTL and testbench

Execution controller for the TD4 core. It replaces the free-running divided CPU clock with a single-cycle clock-enable pulse `cpu_ce`, so the core can run, pause, single-step, stop on a PC breakpoint, or halt on a jump-to-self. The block sits between the board buttons and the CPU registers (`register`, `program_counter`). Those registers run on `clk` and load only when `cpu_ce` is high.

---
 rtl/td4_run_ctrl.sv | 144 ++++++++++++++
 tb/tb_td4_run_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/td4_run_ctrl.sv
// Execution controller for the TD4 core: turns debounced run/step buttons,
// a PC breakpoint and jump-to-self detection into a single-cycle cpu_ce.
module td4_run_ctrl #(
    parameter int LEN_CLOCK = 500000,
    parameter int DEBOUNCE  = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_btn,
    input  logic       step_btn,
    input  logic       bp_en,
    input  logic [3:0] bp_addr,
    input  logic [3:0] pc,
    input  logic [3:0] op,
    input  logic [3:0] im,
    output logic       cpu_ce,
    output logic [1:0] state,
    output logic [1:0] halt_cause,
    output logic [7:0] instr_count
);

    localparam int DIV_W = (LEN_CLOCK > 2) ? $clog2(LEN_CLOCK) : 1;
    localparam int DB_W  = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(LEN_CLOCK - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_STEP = 2'b10;
    localparam logic [1:0] S_HALT = 2'b11;

    // Bit 0 is the run button, bit 1 the step button.
    logic [1:0]      btn_raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      level;
    logic [1:0]      level_d;
    logic [DB_W-1:0] db_cnt [2];
    logic            run_p;
    logic            step_p;

    assign btn_raw = {step_btn, run_btn};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= '0;
            sync2     <= '0;
            level     <= '0;
            level_d   <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            level_d <= level;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign run_p  = level[0] & ~level_d[0];
    assign step_p = level[1] & ~level_d[1];

    logic [DIV_W-1:0] div;
    logic             skip_bp;
    logic             bp_hit;
    logic             self_jump;

    assign bp_hit    = bp_en && (pc == bp_addr) && !skip_bp;
    assign self_jump = (op == 4'b1111) && (im == pc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cpu_ce      <= 1'b0;
            halt_cause  <= 2'b00;
            instr_count <= '0;
            div         <= '0;
            skip_bp     <= 1'b0;
        end else begin
            cpu_ce <= 1'b0;
            if (cpu_ce) instr_count <= instr_count + 8'd1;
            case (state)
                S_IDLE: begin
                    div <= '0;
                    if (run_p) begin
                        state <= S_RUN;
                    end else if (step_p) begin
                        state  <= S_STEP;
                        cpu_ce <= 1'b1;
                    end
                end
                S_RUN: begin
                    // A pause request beats a tick landing on the same edge.
                    if (run_p) begin
                        state   <= S_IDLE;
                        div     <= '0;
                        skip_bp <= 1'b0;
                    end else if (div == DIV_LAST) begin
                        div <= '0;
                        if (bp_hit) begin
                            state      <= S_HALT;
                            halt_cause <= 2'b01;
                            skip_bp    <= 1'b0;
                        end else if (self_jump) begin
                            state      <= S_HALT;
                            halt_cause <= 2'b10;
                            skip_bp    <= 1'b0;
                        end else begin
                            cpu_ce  <= 1'b1;
                            skip_bp <= 1'b0;
                        end
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                S_STEP: begin
                    state <= S_IDLE;
                end
                default: begin
                    div <= '0;
                    if (run_p) begin
                        state      <= S_RUN;
                        skip_bp    <= 1'b1;
                        halt_cause <= 2'b00;
                    end else if (step_p) begin
                        state      <= S_STEP;
                        cpu_ce     <= 1'b1;
                        halt_cause <= 2'b00;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Bench for td4_run_ctrl: timed event scoreboard fed by an arithmetic model of
// run segments and single steps, plus direct reset and wrap checks.
module tb_td4_run_ctrl;

    localparam int LEN = 4;
    localparam int DB  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       run_btn;
    logic       step_btn;
    logic       bp_en;
    logic [3:0] bp_addr;
    logic [3:0] pc;
    logic [3:0] op;
    logic [3:0] im;
    logic       cpu_ce;
    logic [1:0] state;
    logic [1:0] halt_cause;
    logic [7:0] instr_count;

    td4_run_ctrl #(.LEN_CLOCK(LEN), .DEBOUNCE(DB)) dut (
        .clk(clk), .rst(rst), .run_btn(run_btn), .step_btn(step_btn),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .op(op), .im(im),
        .cpu_ce(cpu_ce), .state(state), .halt_cause(halt_cause),
        .instr_count(instr_count)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected events: {kind, cycle, a, b}; kind 0 = cpu_ce pulse
    // (a = instr_count, b = pc), kind 1 = state change (a = state, b = cause).
    logic [37:0] exp_q[$];

    logic [3:0] m_pc;
    logic [7:0] m_cnt;
    logic [1:0] m_state;
    bit         m_skip;
    logic [1:0] mon_prev;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic sb_check(input logic [1:0] kind, input logic [7:0] a, input logic [7:0] b);
        logic [37:0] got;
        logic [37:0] exp;
        got = {kind, 20'(cyc), a, b};
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got kind=%0d cyc=%0d a=%0h b=%0h, expected no event",
                     kind, cyc, a, b);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                n_fail++;
                $display("FAIL sb_event: got kind=%0d cyc=%0d a=%0h b=%0h, expected kind=%0d cyc=%0d a=%0h b=%0h",
                         got[37:36], got[35:16], got[15:8], got[7:0],
                         exp[37:36], exp[35:16], exp[15:8], exp[7:0]);
            end
        end
    endtask

    // Monitor: samples mid-cycle, pops one expectation per observed event.
    initial begin
        mon_prev = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_prev = 2'b00;
            end else begin
                if (state !== mon_prev) begin
                    sb_check(2'd1, {6'd0, state}, {6'd0, halt_cause});
                    mon_prev = state;
                end
                if (cpu_ce) sb_check(2'd0, instr_count, {4'd0, pc});
            end
        end
    end

    // One clock; the bench CPU advances its PC on every enabled edge.
    task automatic cyc_wait();
        logic ce_was;
        @(negedge clk);
        ce_was = cpu_ce;
        @(posedge clk);
        #1;
        if (ce_was && rst) pc = pc + 4'd1;
    endtask

    task automatic wait_until(input int t);
        int guard;
        guard = 0;
        while (cyc < t && guard < 5000) begin
            cyc_wait();
            guard++;
        end
    endtask

    task automatic press(input bit r, input bit s, input int hold);
        run_btn  = r;
        step_btn = s;
        repeat (hold) cyc_wait();
        run_btn  = 1'b0;
        step_btn = 1'b0;
    endtask

    task automatic push_state(input int t, input logic [1:0] s, input logic [1:0] c);
        exp_q.push_back({2'd1, 20'(t), 6'd0, s, 6'd0, c});
    endtask

    task automatic push_pulse(input int t);
        exp_q.push_back({2'd0, 20'(t), m_cnt, 4'd0, m_pc});
    endtask

    // Ticks land every LEN cycles after RUN entry at r; a pause lands at x (0 = none).
    task automatic model_run(input int r, input int x, output int end_t, output bit halted);
        int t;
        halted = 1'b0;
        end_t  = r;
        for (int k = 1; k < 2000; k++) begin
            t = r + LEN * k;
            if (x > 0 && t >= x) begin
                push_state(x, 2'b00, 2'b00);
                end_t = x; m_state = 2'b00; m_skip = 1'b0;
                return;
            end
            if (bp_en && m_pc == bp_addr && !m_skip) begin
                push_state(t, 2'b11, 2'b01);
                end_t = t; halted = 1'b1; m_state = 2'b11; m_skip = 1'b0;
                return;
            end
            if (op == 4'hF && im == m_pc) begin
                push_state(t, 2'b11, 2'b10);
                end_t = t; halted = 1'b1; m_state = 2'b11; m_skip = 1'b0;
                return;
            end
            push_pulse(t);
            m_cnt  = m_cnt + 8'd1;
            m_pc   = m_pc + 4'd1;
            m_skip = 1'b0;
        end
    endtask

    task automatic run_segment(input int n, input int off, input bit both);
        int  c;
        int  r;
        int  x;
        int  end_t;
        bit  halted;
        c  = cyc;
        r  = c + 3 + DB;
        x  = (n > 0) ? r + LEN * n + off : 0;
        pc = m_pc;
        m_skip = (m_state == 2'b11);
        push_state(r, 2'b01, 2'b00);
        model_run(r, x, end_t, halted);
        press(1'b1, both, $urandom_range(DB + 1, 6));
        if (!halted) begin
            wait_until(x - 3 - DB);
            press(1'b1, 1'b0, $urandom_range(DB + 1, 6));
        end
        wait_until(end_t + DB + 4);
    endtask

    task automatic step_once();
        int s;
        s = cyc + 3 + DB;
        pc = m_pc;
        push_state(s, 2'b10, 2'b00);
        push_pulse(s);
        push_state(s + 1, 2'b00, 2'b00);
        m_cnt   = m_cnt + 8'd1;
        m_pc    = m_pc + 4'd1;
        m_state = 2'b00;
        m_skip  = 1'b0;
        press(1'b0, 1'b1, $urandom_range(DB + 1, 6));
        wait_until(s + DB + 4);
    endtask

    initial begin
        int s;
        rst = 1'b0; run_btn = 1'b0; step_btn = 1'b0;
        bp_en = 1'b0; bp_addr = 4'd0; pc = 4'd0; op = 4'd0; im = 4'd0;
        m_pc = 4'd0; m_cnt = 8'd0; m_state = 2'b00; m_skip = 1'b0;

        // Reset held with buttons bouncing, then released.
        repeat (8) begin
            cyc_wait();
            run_btn  = 1'($urandom_range(0, 1));
            step_btn = 1'($urandom_range(0, 1));
            check("reset_hold", 32'({cpu_ce, state, halt_cause, instr_count}), 32'd0);
        end
        run_btn = 1'b0; step_btn = 1'b0; rst = 1'b1;
        repeat (6) begin
            cyc_wait();
            check("reset_release", 32'({cpu_ce, state, halt_cause, instr_count}), 32'd0);
        end

        // Plain run and pause.
        run_segment(4, 1, 1'b0);
        check("count_after_run", 32'(instr_count), 32'd4);

        // Bounce rejected, clean step, simultaneous run+step.
        press(1'b0, 1'b1, $urandom_range(1, DB - 1));
        wait_until(cyc + 10);
        check("glitch_idle", 32'(state), 32'd0);
        step_once();
        check("count_after_step", 32'(instr_count), 32'd5);
        run_segment(3, 2, 1'b1);

        // Breakpoint at 3, then resume through it with a pause landing on a tick.
        bp_en = 1'b1; bp_addr = 4'd3; m_pc = 4'd0;
        run_segment(0, 0, 1'b0);
        check("bp_halt", 32'({state, halt_cause}), 32'b1101);
        run_segment(5, 0, 1'b0);
        check("bp_resume_idle", 32'({state, halt_cause}), 32'b0000);
        bp_en = 1'b0;

        // Self-jump at 15: halts, re-halts on resume, step escapes.
        m_pc = 4'd15; op = 4'hF; im = 4'hF;
        run_segment(0, 0, 1'b0);
        check("sj_halt", 32'({state, halt_cause}), 32'b1110);
        run_segment(0, 0, 1'b0);
        check("sj_rehalt", 32'({state, halt_cause}), 32'b1110);
        step_once();
        op = 4'd0; im = 4'd0;

        // Randomized mix of runs and steps.
        for (int i = 0; i < 12; i++) begin
            bp_en   = 1'($urandom_range(0, 1));
            bp_addr = 4'($urandom_range(0, 15));
            op      = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            im      = 4'($urandom_range(0, 15));
            m_pc    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) step_once();
            else run_segment($urandom_range(3, 6), $urandom_range(0, LEN - 1), 1'($urandom_range(0, 1)));
        end
        if (m_state != 2'b00) step_once();
        bp_en = 1'b0; op = 4'd0; im = 4'd0;

        // Asynchronous reset inside the cpu_ce cycle of a step.
        s = cyc + 3 + DB;
        press(1'b0, 1'b1, DB + 2);
        wait_until(s);
        check("step_ce_high", 32'(cpu_ce), 32'd1);
        rst = 1'b0;
        #1;
        check("ce_async_drop", 32'({cpu_ce, state}), 32'd0);
        repeat (3) cyc_wait();
        rst = 1'b1;
        m_pc = 4'd0; m_cnt = 8'd0; m_state = 2'b00; m_skip = 1'b0; pc = 4'd0;
        cyc_wait();
        check("post_reset_count", 32'({state, instr_count}), 32'd0);

        // 256 instructions bring the counter back to zero.
        run_segment(256, 1, 1'b0);
        check("wrap_count", 32'(instr_count), 32'd0);

        wait_until(cyc + 10);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
